pf_ccc_clk_en_seq: RTL

Parametrised fabric-side companion to the PolarFire CCC/PLL wrapper: qualifies the PLL lock, sequences a fabric reset, and derives NUM_CH independently programmable clock-enable strobes and 50%-duty toggle outputs from the single CCC fabric clock. Detects and counts loss-of-lock events and realigns all channels on demand. Sits directly after the CCC, feeding fabric logic with enables rather than extra global clocks.

---
 rtl/pf_ccc_clk_en_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pf_ccc_clk_en_seq.sv
// pf_ccc_clk_en_seq
// Fabric-side companion to the CCC/PLL: synchronises and qualifies PLL lock,
// sequences the downstream fabric reset, and derives NUM_CH programmable
// clock-enable strobes plus 50%-duty toggles from the single fabric clock.
// Loss-of-lock events are flagged (sticky) and counted (saturating).
module pf_ccc_clk_en_seq #(
   parameter int NUM_CH    = 4,
   parameter int DIV_W     = 8,
   parameter int LOCK_QUAL = 16
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      PLL_LOCK,
   input  logic [NUM_CH*DIV_W-1:0]   DIV_VAL,
   input  logic                      DIV_LOAD,
   input  logic                      CLR_STICKY,
   output logic [NUM_CH-1:0]         CE,
   output logic [NUM_CH-1:0]         TGL,
   output logic                      READY,
   output logic                      FABRIC_RESET,
   output logic                      LOCK_LOST,
   output logic [7:0]                LOSS_CNT
);

   localparam int QW = (LOCK_QUAL > 1) ? $clog2(LOCK_QUAL) : 1;
   localparam logic [QW-1:0] QUAL_LAST = QW'(LOCK_QUAL - 1);

   typedef enum logic [1:0] {
      S_WAIT_LOCK = 2'd0,
      S_QUALIFY   = 2'd1,
      S_RUN       = 2'd2,
      S_LOST      = 2'd3
   } state_t;

   // Lock synchroniser
   logic             lock_meta_q, lock_meta_d;
   logic             lock_s_q, lock_s_d;

   // Sequencer
   state_t           state_q, state_d;
   logic [QW-1:0]    qual_q, qual_d;
   logic             ready_q, ready_d;

   // Sticky loss status
   logic             lock_lost_q, lock_lost_d;
   logic [7:0]       loss_cnt_q, loss_cnt_d;

   // Divider channels
   logic [DIV_W-1:0] shadow_q [NUM_CH];
   logic [DIV_W-1:0] shadow_d [NUM_CH];
   logic [DIV_W-1:0] cnt_q    [NUM_CH];
   logic [DIV_W-1:0] cnt_d    [NUM_CH];
   logic [DIV_W-1:0] d_eff    [NUM_CH];
   logic [NUM_CH-1:0] last_cnt;
   logic [NUM_CH-1:0] ce;
   logic [NUM_CH-1:0] tgl_q, tgl_d;

   // Lock synchroniser and lock-qualification sequencer next state
   always_comb begin
      lock_meta_d = PLL_LOCK;
      lock_s_d    = lock_meta_q;
      state_d     = state_q;
      qual_d      = qual_q;
      case (state_q)
         S_WAIT_LOCK: begin
            if (lock_s_q) begin
               state_d = S_QUALIFY;
               qual_d  = '0;
            end
         end
         S_QUALIFY: begin
            if (!lock_s_q) begin
               state_d = S_WAIT_LOCK;
            end else if (qual_q == QUAL_LAST) begin
               state_d = S_RUN;
            end else begin
               qual_d = qual_q + QW'(1);
            end
         end
         S_RUN: begin
            if (!lock_s_q) begin
               state_d = S_LOST;
            end
         end
         S_LOST: begin
            state_d = S_WAIT_LOCK;
         end
         default: begin
            state_d = S_WAIT_LOCK;
         end
      endcase
      ready_d = (state_d == S_RUN);
   end

   // Sticky loss flag and saturating loss counter; a loss beats a clear
   always_comb begin
      lock_lost_d = lock_lost_q;
      loss_cnt_d  = loss_cnt_q;
      if (CLR_STICKY) begin
         lock_lost_d = 1'b0;
         loss_cnt_d  = '0;
      end
      if (state_q == S_LOST) begin
         lock_lost_d = 1'b1;
         if (CLR_STICKY) begin
            loss_cnt_d = 8'd1;
         end else if (loss_cnt_q != 8'hFF) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
         end
      end
   end

   // Per-channel divisor shadow, counter, enable strobe and toggle
   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         d_eff[i]    = (shadow_q[i] == '0) ? DIV_W'(1) : shadow_q[i];
         last_cnt[i] = (cnt_q[i] == d_eff[i] - DIV_W'(1));
         ce[i]       = (state_q == S_RUN) && last_cnt[i];
         shadow_d[i] = DIV_LOAD ? DIV_VAL[i*DIV_W +: DIV_W] : shadow_q[i];
         if (DIV_LOAD || (state_q != S_RUN) || last_cnt[i]) begin
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + DIV_W'(1);
         end
         // Toggle is forced low in any cycle that will not be RUN, so it is
         // already 0 during the LOST cycle.
         tgl_d[i] = (state_d == S_RUN) ? (tgl_q[i] ^ ce[i]) : 1'b0;
      end
   end

   // All state registers; synchronous reset also reloads the divisor shadows
   always_ff @(posedge CLK) begin
      if (RESET) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         state_q     <= S_WAIT_LOCK;
         qual_q      <= '0;
         ready_q     <= 1'b0;
         lock_lost_q <= 1'b0;
         loss_cnt_q  <= '0;
         tgl_q       <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= DIV_VAL[i*DIV_W +: DIV_W];
            cnt_q[i]    <= '0;
         end
      end else begin
         lock_meta_q <= lock_meta_d;
         lock_s_q    <= lock_s_d;
         state_q     <= state_d;
         qual_q      <= qual_d;
         ready_q     <= ready_d;
         lock_lost_q <= lock_lost_d;
         loss_cnt_q  <= loss_cnt_d;
         tgl_q       <= tgl_d;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= shadow_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
      end
   end

   assign CE           = ce;
   assign TGL          = tgl_q;
   assign READY        = ready_q;
   assign FABRIC_RESET = ~ready_q;
   assign LOCK_LOST    = lock_lost_q;
   assign LOSS_CNT     = loss_cnt_q;

endmodule
